// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder: buffers host message bytes in a small FIFO and streams
// them to a hash core, then waits for the digest, compares it against the
// expected value and reports completion with done/match/err.
module hash_msg_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        fifo_full,
  input  logic        start,
  input  logic [63:0] msg_len,
  input  logic [31:0] exp_digest,
  output logic        busy,
  output logic        M_valid,
  output logic [7:0]  M,
  output logic [63:0] C_in,
  input  logic        hash_ready,
  input  logic [31:0] digest,
  output logic        done,
  output logic [31:0] digest_out,
  output logic        match,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  // Last timeout count value: WAIT_DIG may last at most TIMEOUT cycles.
  localparam logic [TW-1:0] TLAST_C = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_DIG = 2'd2,
    FIN      = 2'd3
  } state_t;

  state_t        state_r;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [63:0]   c_in_r;
  logic [31:0]   exp_r;
  logic [63:0]   byte_cnt_r;
  logic [TW-1:0] tcnt_r;
  logic          abort_r;
  logic          done_r;
  logic          err_r;
  logic          match_r;
  logic [31:0]   digest_out_r;
  logic [7:0]    m_last_r;
  logic          push_s;
  logic          pop_s;
  logic          empty_s;

  assign empty_s   = (count_r == {CW{1'b0}});
  assign fifo_full = (count_r == DEPTH_C);
  assign push_s    = wr_en && !fifo_full;
  // A byte leaves the FIFO in the same cycle it is presented on M.
  assign pop_s     = (state_r == SEND) && !empty_s;

  assign busy       = (state_r != IDLE);
  assign M_valid    = pop_s;
  // During stall bubbles M keeps showing the last byte that was sent.
  assign M          = pop_s ? mem_r[rd_ptr_r] : m_last_r;
  assign C_in       = c_in_r;
  assign done       = done_r;
  assign err        = err_r;
  assign match      = match_r;
  assign digest_out = digest_out_r;

  // FIFO storage: data array needs no reset, occupancy is tracked by count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Job sequencer: latch job, stream bytes, await digest, report result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      c_in_r       <= 64'd0;
      exp_r        <= 32'd0;
      byte_cnt_r   <= 64'd0;
      tcnt_r       <= {TW{1'b0}};
      abort_r      <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      match_r      <= 1'b0;
      digest_out_r <= 32'd0;
      m_last_r     <= 8'd0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (pop_s) begin
        m_last_r <= mem_r[rd_ptr_r];
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            if (msg_len != 64'd0) begin
              c_in_r     <= msg_len;
              exp_r      <= exp_digest;
              byte_cnt_r <= 64'd0;
              match_r    <= 1'b0;
              abort_r    <= 1'b0;
              state_r    <= SEND;
            end else begin
              // Empty message is rejected without starting a job.
              err_r <= 1'b1;
            end
          end
        end
        SEND: begin
          // hash_ready is deliberately not looked at here.
          if (pop_s) begin
            if (byte_cnt_r == (c_in_r - 64'd1)) begin
              tcnt_r  <= {TW{1'b0}};
              state_r <= WAIT_DIG;
            end else begin
              byte_cnt_r <= byte_cnt_r + 64'd1;
            end
          end
        end
        WAIT_DIG: begin
          if (hash_ready) begin
            digest_out_r <= digest;
            match_r      <= (digest == exp_r);
            state_r      <= FIN;
          end else if (tcnt_r == TLAST_C) begin
            digest_out_r <= 32'd0;
            match_r      <= 1'b0;
            abort_r      <= 1'b1;
            state_r      <= FIN;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        FIN: begin
          done_r  <= 1'b1;
          err_r   <= abort_r;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Self-checking bench for hash_msg_feeder: a table of complete jobs plus
// directed sequences for FIFO overflow, stalls, rejection and reset abort.
module tb_hash_msg_feeder;

  localparam int DEPTH = 16;
  localparam int TMO   = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        fifo_full;
  logic        start;
  logic [63:0] msg_len;
  logic [31:0] exp_digest;
  logic        busy;
  logic        M_valid;
  logic [7:0]  M;
  logic [63:0] C_in;
  logic        hash_ready;
  logic [31:0] digest;
  logic        done;
  logic [31:0] digest_out;
  logic        match;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hash_msg_feeder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_full(fifo_full), .start(start), .msg_len(msg_len),
    .exp_digest(exp_digest), .busy(busy), .M_valid(M_valid), .M(M),
    .C_in(C_in), .hash_ready(hash_ready), .digest(digest), .done(done),
    .digest_out(digest_out), .match(match), .err(err)
  );

  typedef struct {
    int          len;
    logic [31:0] expd;
    logic [31:0] dig;
    int          dly;      // cycles in WAIT_DIG before hash_ready; <0 = never
    logic        hr_send;  // hold hash_ready high during SEND
    logic        e_match;
    logic        e_err;
    logic [31:0] e_dout;
  } job_t;

  job_t jobs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input job_t j);
    int pre;
    int nw;
    pre = (j.len < 15) ? j.len : 15;
    for (int i = 0; i < pre; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); tick();
    end
    wr_en = 1'b0;
    start = 1'b1; msg_len = 64'(j.len); exp_digest = j.expd; tick();
    start = 1'b0; msg_len = 64'd0;
    nw = pre;
    for (int k = 0; k < j.len; k++) begin
      chk("stream_valid", {63'd0, M_valid}, 64'd1);
      chk("stream_byte", {56'd0, M}, 64'(k % 256));
      chk("c_in_stable", C_in, 64'(j.len));
      if (k == 1) begin
        start = 1'b1; msg_len = 64'd7;   // must be ignored outside IDLE
      end else begin
        start = 1'b0; msg_len = 64'd0;
      end
      if (nw < j.len) begin
        wr_en = 1'b1; wr_data = 8'(nw); nw++;
      end else begin
        wr_en = 1'b0;
      end
      hash_ready = j.hr_send; digest = 32'hBAD0BAD0;
      tick();
    end
    start = 1'b0; wr_en = 1'b0; hash_ready = 1'b0; digest = 32'd0;
    chk("wait_mvalid", {63'd0, M_valid}, 64'd0);
    chk("wait_busy", {63'd0, busy}, 64'd1);
    if (j.dly < 0) begin
      for (int c = 0; c <= TMO; c++) begin
        chk("no_early_done", {63'd0, done}, 64'd0);
        tick();
      end
    end else begin
      for (int c = 0; c < j.dly; c++) tick();
      hash_ready = 1'b1; digest = j.dig; tick();
      hash_ready = 1'b0; digest = 32'd0;
      chk("fin_no_done", {63'd0, done}, 64'd0);
      chk("fin_busy", {63'd0, busy}, 64'd1);
      tick();
    end
    chk("done", {63'd0, done}, 64'd1);
    chk("err", {63'd0, err}, {63'd0, j.e_err});
    chk("match", {63'd0, match}, {63'd0, j.e_match});
    chk("digest_out", {32'd0, digest_out}, {32'd0, j.e_dout});
    chk("idle_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("done_pulse", {63'd0, done}, 64'd0);
    chk("err_pulse", {63'd0, err}, 64'd0);
    chk("match_hold", {63'd0, match}, {63'd0, j.e_match});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int w;
    int cyc;
    logic [7:0] last;

    jobs[0] = '{50, 32'hDEADBEEF, 32'hDEADBEEF, 3,   1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    jobs[1] = '{4,  32'h12345678, 32'h12345679, 0,   1'b0, 1'b0, 1'b0, 32'h12345679};
    jobs[2] = '{4,  32'hAAAA5555, 32'h00000000, -1,  1'b0, 1'b0, 1'b1, 32'h00000000};
    jobs[3] = '{1,  32'h0F0F0F0F, 32'h0F0F0F0F, 19,  1'b1, 1'b1, 1'b0, 32'h0F0F0F0F};
    jobs[4] = '{17, 32'h00000001, 32'h00000001, 1,   1'b0, 1'b1, 1'b0, 32'h00000001};

    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'd0; start = 1'b0; msg_len = 64'd0;
    exp_digest = 32'd0; hash_ready = 1'b0; digest = 32'd0;
    tick(); tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_mvalid", {63'd0, M_valid}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_match", {63'd0, match}, 64'd0);
    chk("rst_full", {63'd0, fifo_full}, 64'd0);
    chk("rst_m", {56'd0, M}, 64'd0);
    chk("rst_cin", C_in, 64'd0);
    chk("rst_dout", {32'd0, digest_out}, 64'd0);
    rst_n = 1'b1; tick();

    // Table of complete jobs.
    for (int t = 0; t < 5; t++) begin
      run_job(jobs[t]);
    end

    // Overflow: 20 writes into a 16-deep FIFO, then drain 16 bytes.
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hA0 + i); tick();
      if (i == 14) chk("full_at_15", {63'd0, fifo_full}, 64'd0);
      if (i == 15) chk("full_at_16", {63'd0, fifo_full}, 64'd1);
    end
    wr_en = 1'b0;
    chk("full_at_20", {63'd0, fifo_full}, 64'd1);
    start = 1'b1; msg_len = 64'd16; exp_digest = 32'd0; tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("ovf_valid", {63'd0, M_valid}, 64'd1);
      chk("ovf_byte", {56'd0, M}, 64'(8'hA0 + k));
      tick();
    end
    chk("ovf_drained_valid", {63'd0, M_valid}, 64'd0);
    chk("ovf_drained_full", {63'd0, fifo_full}, 64'd0);
    hash_ready = 1'b1; digest = 32'd0; tick();
    hash_ready = 1'b0; tick();
    chk("ovf_done", {63'd0, done}, 64'd1);
    chk("ovf_match", {63'd0, match}, 64'd1);
    tick();

    // Stalls: empty FIFO at start, one byte written every third cycle.
    start = 1'b1; msg_len = 64'd8; exp_digest = 32'h11; tick();
    start = 1'b0;
    chk("stall_first_empty", {63'd0, M_valid}, 64'd0);
    got = 0; w = 0; cyc = 0; last = 8'd0;
    while (got < 8 && cyc < 100) begin
      if (M_valid) begin
        chk("stall_byte", {56'd0, M}, 64'(8'h40 + got));
        last = M;
        got++;
      end else if (got > 0) begin
        chk("stall_m_hold", {56'd0, M}, {56'd0, last});
      end
      if ((cyc % 3) == 0 && w < 8) begin
        wr_en = 1'b1; wr_data = 8'(8'h40 + w); w++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    chk("stall_count", 64'(got), 64'd8);
    chk("stall_wait_valid", {63'd0, M_valid}, 64'd0);
    hash_ready = 1'b1; digest = 32'h11; tick();
    hash_ready = 1'b0; tick();
    chk("stall_done", {63'd0, done}, 64'd1);
    chk("stall_match", {63'd0, match}, 64'd1);
    tick();

    // Zero-length request is rejected.
    start = 1'b1; msg_len = 64'd0; tick();
    start = 1'b0;
    chk("zero_err", {63'd0, err}, 64'd1);
    chk("zero_busy", {63'd0, busy}, 64'd0);
    chk("zero_done", {63'd0, done}, 64'd0);
    tick();
    chk("zero_err_pulse", {63'd0, err}, 64'd0);
    chk("zero_busy2", {63'd0, busy}, 64'd0);

    // Reset in the middle of a 30-byte job.
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i); tick();
    end
    wr_en = 1'b0;
    start = 1'b1; msg_len = 64'd30; exp_digest = 32'd5; tick();
    start = 1'b0; tick(); tick();
    chk("mid_sending", {63'd0, M_valid}, 64'd1);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk("mid_busy", {63'd0, busy}, 64'd0);
    chk("mid_mvalid", {63'd0, M_valid}, 64'd0);
    chk("mid_full", {63'd0, fifo_full}, 64'd0);
    chk("mid_cin", C_in, 64'd0);
    chk("mid_m", {56'd0, M}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      chk("mid_no_done", {63'd0, done}, 64'd0);
      chk("mid_no_err", {63'd0, err}, 64'd0);
      tick();
    end
    start = 1'b1; msg_len = 64'd2; exp_digest = 32'd0; tick();
    start = 1'b0;
    chk("mid_fifo_empty", {63'd0, M_valid}, 64'd0);
    chk("mid_restart_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("mid_fifo_empty2", {63'd0, M_valid}, 64'd0);
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hash_msg_feeder.md
HASH_MSG_FEEDER -- requirements
Module: hash_msg_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: byte FIFO depth, power of two, at least 4.
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles in WAIT_DIG before abort.
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 wr_en  input  1  host byte write strobe; ignored when fifo_full is 1.
REQ-006 wr_data  input  8  host byte.
REQ-007 fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-008 start  input  1  single-cycle request to hash msg_len bytes; sampled only in IDLE.
REQ-009 msg_len  input  64  message length in bytes, sampled with start.
REQ-010 exp_digest  input  32  expected digest, sampled with start.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 M_valid  output  1  byte-valid toward the hash core.
REQ-013 M  output  8  message byte toward the hash core.
REQ-014 C_in  output  64  latched msg_len, held stable for the whole job.
REQ-015 hash_ready  input  1  hash core digest-valid.
REQ-016 digest  input  32  hash core digest.
REQ-017 done  output  1  one-cycle job-complete pulse.
REQ-018 digest_out  output  32  captured digest, held until the next done.
REQ-019 match  output  1  digest_out equals latched exp_digest; valid from done until the next start.
REQ-020 err  output  1  one-cycle pulse accompanying done when the job was aborted or rejected.

Function
REQ-021 FSM states SHALL be IDLE, SEND, WAIT_DIG, FIN.
REQ-022 IDLE with start=1 and msg_len!=0: latch msg_len into C_in, latch exp_digest, clear the byte counter, clear match, go to SEND.
REQ-023 IDLE with start=1 and msg_len==0: stay in IDLE and pulse err the next cycle; done is not pulsed.
REQ-024 SEND, each cycle with a non-empty FIFO: pop one byte, drive it on M with M_valid=1 in the same cycle, and increment the byte counter.
REQ-025 SEND with an empty FIFO: M_valid=0, counter held (stall bubble); M holds its last value.
REQ-026 When the byte counter reaches C_in-1 and a byte is sent: go to WAIT_DIG; the last byte is popped in that cycle and no further bytes are popped.
REQ-027 M_valid SHALL be 0 in IDLE, WAIT_DIG and FIN.
REQ-028 WAIT_DIG: clear and start the timeout counter on entry; on hash_ready=1, register digest into digest_out, set match=(digest==exp_digest), go to FIN.
REQ-029 WAIT_DIG timeout: when the timeout counter reaches TIMEOUT without hash_ready, go to FIN with err flagged; digest_out is then 0 and match is 0.
REQ-030 hash_ready asserted while in SEND SHALL be ignored.
REQ-031 FIN: pulse done for one cycle (with err if flagged), return to IDLE; FIN lasts exactly one cycle.
REQ-032 FIFO: a write and a pop in the same cycle are both honoured and the count is unchanged.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 A write when full is dropped with no corruption; host writes are accepted in every state.
REQ-035 Latency: first M_valid occurs the cycle after start if the FIFO is non-empty; done occurs 2 cycles after the hash_ready sample.
REQ-036 start outside IDLE SHALL be ignored.

Reset
REQ-037 rst_n=0 at a clock edge SHALL force the FSM to IDLE and clear the FIFO (empty, pointers 0) and all counters.
REQ-038 rst_n=0 at a clock edge SHALL drive busy, M_valid, done, err, match, fifo_full to 0 and M, C_in, digest_out to 0.
REQ-039 A reset mid-job SHALL abort the job with no done or err pulse.

Verification
REQ-040 Preload bytes 0..49; start with msg_len=50 -> M_valid high for 50 consecutive cycles, M=0..49, C_in=50 throughout; hash_ready with digest=exp_digest -> done=1, match=1, err=0.
REQ-041 Start msg_len=8 with FIFO empty; write 1 byte every 3rd cycle -> M_valid gaps, exactly 8 bytes sent in order, no duplicates.
REQ-042 Write 20 bytes into a FIFO_DEPTH=16 FIFO -> fifo_full after 16; bytes 17-20 dropped; 16 bytes later read out intact.
REQ-043 Job of 4 bytes, hash_ready never asserted -> done and err pulse together TIMEOUT+1 cycles after WAIT_DIG entry; match=0, digest_out=0.
REQ-044 Start with msg_len=0 -> err pulse, busy stays 0, no done; assert rst_n=0 during SEND of a 30-byte job -> next cycle IDLE, M_valid=0, FIFO empty.
REQ-045 digest differs from exp_digest -> done=1, match=0, digest_out equals the digest sampled.
